// File: rtl/jpeg_pkg.sv
// Shared types for the JPEG encoder front end: block geometry, component
// tags, scheduler FSM states and the per-sample beat carried to the DCT.
package jpeg_pkg;

  localparam int BLK_N       = 8;
  localparam int BLK_SAMPLES = 64;

  typedef enum logic [1:0] {
    Y  = 2'd0,
    CB = 2'd1,
    CR = 2'd2
  } comp_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic [7:0] data;
    comp_e      comp;
    logic       first;
    logic       last;
  } beat_t;

  // RAM words are packed {y, cb, cr}; pick the byte for one component.
  function automatic logic [7:0] lane_sel(input logic [23:0] w, input comp_e c);
    case (c)
      CB:      lane_sel = w[15:8];
      CR:      lane_sel = w[7:0];
      default: lane_sel = w[23:16];
    endcase
  endfunction

endpackage

// File: rtl/dpram_sd.sv
// Simple dual-port RAM, one write and one registered read port.
// Address MSB selects the bank; the lower bits index inside the bank.
module dpram_sd #(
  parameter int DW         = 24,
  parameter int BANK_DEPTH = 128,
  parameter int AW         = $clog2(BANK_DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW:0]   waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW:0]   raddr,
  output logic [DW-1:0] rdata
);
  localparam int DEPTH = 2 * BANK_DEPTH;
  localparam int IW    = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [IW-1:0] widx, ridx;

  // Banks are packed back to back so a non power-of-two width wastes nothing.
  function automatic logic [IW-1:0] to_idx(input logic [AW:0] a);
    to_idx = IW'(a[AW-1:0]) + (a[AW] ? IW'(BANK_DEPTH) : IW'(0));
  endfunction

  assign widx = to_idx(waddr);
  assign ridx = to_idx(raddr);

  // Write port and 1-cycle registered read; rdata holds when re is low.
  always_ff @(posedge clk) begin
    if (we) mem[widx] <= wdata;
    if (re) rdata <= mem[ridx];
  end

endmodule

// File: rtl/ycbcr_block_sched.sv
// Raster-to-block scheduler: captures 8-line YCbCr 4:4:4 strips into a
// ping-pong RAM and replays each completed strip as 8x8 blocks ordered
// Y, Cb, Cr per block column, over a valid/ready stream to the DCT.
module ycbcr_block_sched
  import jpeg_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int COL_W      = $clog2(IMG_WIDTH)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sof,
  input  logic [7:0] ycbcr_y,
  input  logic [7:0] ycbcr_cb,
  input  logic [7:0] ycbcr_cr,
  input  logic       ycbcr_de,
  output logic [7:0] blk_data,
  output logic [1:0] blk_comp,
  output logic       blk_valid,
  input  logic       blk_ready,
  output logic       blk_first,
  output logic       blk_last,
  output logic       frame_done,
  output logic       err_ovf
);
  localparam int N_BX       = IMG_WIDTH / BLK_N;
  localparam int N_STRIP    = IMG_HEIGHT / BLK_N;
  localparam int BANK_DEPTH = BLK_N * IMG_WIDTH;
  localparam int AW         = $clog2(BANK_DEPTH);
  localparam int BX_W       = (N_BX > 1) ? $clog2(N_BX) : 1;
  localparam int SW         = (N_STRIP > 1) ? $clog2(N_STRIP) : 1;

  // ---------------- write side ----------------
  logic [COL_W-1:0] col;
  logic [2:0]       line;
  logic             wr_bank;
  logic [1:0]       full, full_set, full_clr;
  logic             pix_we, wr_wrap;
  logic [AW-1:0]    wr_off;

  assign pix_we   = ycbcr_de && !sof;
  assign wr_wrap  = pix_we && (col == COL_W'(IMG_WIDTH - 1)) && (line == 3'(BLK_N - 1));
  assign wr_off   = AW'(int'(line) * IMG_WIDTH + int'(col));
  assign full_set = wr_wrap ? (2'b01 << wr_bank) : 2'b00;

  // Raster position tracking and sticky overflow detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col     <= '0;
      line    <= '0;
      wr_bank <= 1'b0;
      err_ovf <= 1'b0;
    end else if (sof) begin
      col     <= '0;
      line    <= '0;
      wr_bank <= 1'b0;
      err_ovf <= 1'b0;
    end else if (ycbcr_de) begin
      if (full[wr_bank]) err_ovf <= 1'b1;
      if (col == COL_W'(IMG_WIDTH - 1)) begin
        col <= '0;
        if (line == 3'(BLK_N - 1)) begin
          line    <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          line <= line + 3'd1;
        end
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Bank full flags; a write-side set beats a read-side clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   full <= 2'b00;
    else if (sof) full <= 2'b00;
    else          full <= (full & ~full_clr) | full_set;
  end

  // ---------------- read side ----------------
  state_e        state;
  logic [BX_W-1:0] bx;
  comp_e         comp;
  logic [5:0]    s;
  logic          rd_bank;
  logic [SW-1:0] rd_strip;
  logic          issue, acc, drain_done;
  logic [AW-1:0] rd_off;
  logic [23:0]   ram_q;

  logic  q_vld, skid_vld;
  comp_e q_comp;
  logic  q_first, q_last;
  beat_t skid, ram_beat, head;

  // Reads are only issued while the skid is empty, so the RAM output can
  // always be parked there and ready never feeds the address path.
  assign issue      = (state == RUN) && !skid_vld && !sof;
  assign blk_valid  = q_vld || skid_vld;
  assign acc        = blk_valid && blk_ready;
  assign drain_done = (state == DRAIN) && acc && !(q_vld && skid_vld);
  assign full_clr   = drain_done ? (2'b01 << rd_bank) : 2'b00;
  assign rd_off     = AW'(int'(s[5:3]) * IMG_WIDTH + int'(bx) * BLK_N + int'(s[2:0]));

  dpram_sd #(
    .DW        (24),
    .BANK_DEPTH(BANK_DEPTH),
    .AW        (AW)
  ) u_ram (
    .clk  (clk),
    .we   (pix_we),
    .waddr({wr_bank, wr_off}),
    .wdata({ycbcr_y, ycbcr_cb, ycbcr_cr}),
    .re   (issue),
    .raddr({rd_bank, rd_off}),
    .rdata(ram_q)
  );

  // Block scan FSM: s innermost, then component, then block column.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bx         <= '0;
      comp       <= Y;
      s          <= '0;
      rd_bank    <= 1'b0;
      rd_strip   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (sof) begin
        state    <= IDLE;
        bx       <= '0;
        comp     <= Y;
        s        <= '0;
        rd_bank  <= 1'b0;
        rd_strip <= '0;
      end else begin
        case (state)
          IDLE: if (full[rd_bank]) state <= RUN;
          RUN: if (issue) begin
            if (s != 6'd63) begin
              s <= s + 6'd1;
            end else begin
              s <= '0;
              if (comp == Y)       comp <= CB;
              else if (comp == CB) comp <= CR;
              else begin
                comp <= Y;
                if (bx == BX_W'(N_BX - 1)) begin
                  bx    <= '0;
                  state <= DRAIN;
                end else begin
                  bx <= bx + 1'b1;
                end
              end
            end
          end
          DRAIN: if (drain_done) begin
            rd_bank    <= ~rd_bank;
            state      <= IDLE;
            frame_done <= (rd_strip == SW'(N_STRIP - 1));
            rd_strip   <= (rd_strip == SW'(N_STRIP - 1)) ? '0 : rd_strip + 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign ram_beat = '{data: lane_sel(ram_q, q_comp), comp: q_comp, first: q_first, last: q_last};
  assign head     = skid_vld ? skid : ram_beat;

  // RAM output stage plus 1-entry skid; the skid is always the older beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_vld    <= 1'b0;
      skid_vld <= 1'b0;
      skid     <= '0;
      q_comp   <= Y;
      q_first  <= 1'b0;
      q_last   <= 1'b0;
    end else if (sof) begin
      q_vld    <= 1'b0;
      skid_vld <= 1'b0;
    end else begin
      if (issue) begin
        q_comp  <= comp;
        q_first <= (s == 6'd0);
        q_last  <= (s == 6'd63);
      end
      if (skid_vld) begin
        if (acc) skid_vld <= 1'b0;
      end else if (issue && q_vld && !acc) begin
        skid     <= ram_beat;
        skid_vld <= 1'b1;
      end
      if (issue)                 q_vld <= 1'b1;
      else if (acc && !skid_vld) q_vld <= 1'b0;
    end
  end

  assign blk_data  = blk_valid ? head.data : 8'd0;
  assign blk_comp  = blk_valid ? head.comp : 2'd0;
  assign blk_first = blk_valid && head.first;
  assign blk_last  = blk_valid && head.last;

endmodule
